// File: rtl/full_adder_cell.sv
// Single-bit full adder with a combinational result, a registered copy of
// that result, and a saturating count of valid operations that produce a carry.
module full_adder_cell #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             c_in,
  input  logic             in_valid,
  output logic             sum,
  output logic             c_out,
  output logic             sum_q,
  output logic             c_out_q,
  output logic             valid_q,
  output logic [CNT_W-1:0] carry_cnt
);

  logic             sum_d;
  logic             c_out_d;
  logic             valid_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    sum   = a ^ b ^ c_in;
    c_out = (a & b) | (a & c_in) | (b & c_in);
  end

  always_comb begin
    sum_d   = sum;
    c_out_d = c_out;
    valid_d = in_valid;
    cnt_d   = cnt_q;
    // Hold at all-ones rather than wrapping; saturation is silent.
    if (in_valid && c_out && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= 1'b0;
      c_out_q <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign carry_cnt = cnt_q;

endmodule

// File: tb/tb_full_adder_cell.sv
// Bench for full_adder_cell: directed checks plus randomized traffic scored
// against an arithmetic reference (a + b + c_in, saturating min() counters).
module tb_full_adder_cell;

  logic       clk = 1'b0;
  logic       rst;
  logic       a, b, c_in, in_valid;
  logic       sum, c_out, sum_q, c_out_q, valid_q;
  logic [7:0] carry_cnt;
  logic       sum2, c_out2, sum_q2, c_out_q2, valid_q2;
  logic [1:0] carry_cnt2;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  typedef struct {
    logic        s;
    logic        co;
    int unsigned cnt;
    int unsigned cnt2;
  } exp_t;

  exp_t        sb[$];
  logic        mon_en = 1'b0;
  int unsigned m_cnt, m_cnt2;

  full_adder_cell #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .c_in(c_in), .in_valid(in_valid),
    .sum(sum), .c_out(c_out), .sum_q(sum_q), .c_out_q(c_out_q),
    .valid_q(valid_q), .carry_cnt(carry_cnt)
  );

  full_adder_cell #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .a(a), .b(b), .c_in(c_in), .in_valid(in_valid),
    .sum(sum2), .c_out(c_out2), .sum_q(sum_q2), .c_out_q(c_out_q2),
    .valid_q(valid_q2), .carry_cnt(carry_cnt2)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic int unsigned add3(input logic x, input logic y, input logic z);
    return int'(x) + int'(y) + int'(z);
  endfunction

  function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic drive(input logic x, input logic y, input logic z, input logic v);
    a = x; b = y; c_in = z; in_valid = v;
  endtask

  // Monitor: pops one expected record per valid registered result.
  always @(posedge clk) begin
    if (mon_en) begin
      #1;
      if (valid_q) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rnd_sum_q",   32'(sum_q),      32'(e.s));
          chk("rnd_c_out_q", 32'(c_out_q),    32'(e.co));
          chk("rnd_cnt",     32'(carry_cnt),  e.cnt);
          chk("rnd_cnt2",    32'(carry_cnt2), e.cnt2);
        end
      end
    end
  end

  initial begin
    int unsigned r;
    logic [2:0]  v3;
    rst = 1'b1;
    drive(0, 0, 0, 0);
    #1;
    chk("rst_sum_q",   32'(sum_q),     32'd0);
    chk("rst_c_out_q", 32'(c_out_q),   32'd0);
    chk("rst_valid_q", 32'(valid_q),   32'd0);
    chk("rst_cnt",     32'(carry_cnt), 32'd0);

    // Combinational sweep, c_in as MSB, while reset is held.
    for (int i = 0; i < 8; i++) begin
      v3 = 3'(i);
      a = v3[0]; b = v3[1]; c_in = v3[2];
      #5;
      r = add3(v3[0], v3[1], v3[2]);
      chk("comb_sum",   32'(sum),   r % 2);
      chk("comb_c_out", 32'(c_out), r / 2);
    end

    // Registered path with (1,1,0).
    @(negedge clk);
    rst = 1'b0;
    drive(1, 1, 0, 1);
    @(posedge clk); #1;
    chk("reg_sum_q",   32'(sum_q),     32'd0);
    chk("reg_c_out_q", 32'(c_out_q),   32'd1);
    chk("reg_valid_q", 32'(valid_q),   32'd1);
    chk("reg_cnt",     32'(carry_cnt), 32'd1);

    // Build up sum_q=1, c_out_q=1, carry_cnt=5, then reset between edges.
    repeat (4) begin
      @(negedge clk);
      drive(1, 1, 1, 1);
    end
    @(posedge clk); #1;
    chk("pre_rst_cnt",   32'(carry_cnt), 32'd5);
    chk("pre_rst_sum_q", 32'(sum_q),     32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_sum_q",   32'(sum_q),     32'd0);
    chk("arst_c_out_q", 32'(c_out_q),   32'd0);
    chk("arst_valid_q", 32'(valid_q),   32'd0);
    chk("arst_cnt",     32'(carry_cnt), 32'd0);
    drive(1, 0, 0, 1);
    #1;
    chk("arst_comb_sum",   32'(sum),   32'd1);
    chk("arst_comb_c_out", 32'(c_out), 32'd0);

    // Counter qualification.
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      drive(1, 1, 1, 1);
    end
    repeat (3) begin
      @(negedge clk);
      drive(1, 1, 1, 0);
    end
    @(posedge clk); #1;
    chk("qual_cnt",     32'(carry_cnt), 32'd4);
    chk("qual_valid_q", 32'(valid_q),   32'd0);
    chk("qual_sum_q",   32'(sum_q),     32'd1);
    chk("qual_c_out_q", 32'(c_out_q),   32'd1);
    repeat (3) begin
      @(negedge clk);
      drive(1, 0, 0, 1);
    end
    @(posedge clk); #1;
    chk("nocarry_cnt",     32'(carry_cnt),  32'd4);
    chk("nocarry_c_out_q", 32'(c_out_q),    32'd0);
    chk("nocarry_cnt2",    32'(carry_cnt2), 32'd3);

    // Saturation of the 2-bit counter over 6 qualifying operations.
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0);
    #2;
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      case (k % 4)
        0: drive(1, 1, 0, 1);
        1: drive(0, 1, 1, 1);
        2: drive(1, 0, 1, 1);
        default: drive(1, 1, 1, 1);
      endcase
      @(posedge clk); #1;
      chk("sat_cnt2", 32'(carry_cnt2), sat(32'(k), 3));
    end
    chk("sat_cnt8", 32'(carry_cnt), 32'd6);

    // Reset held through a clock edge with valid input; capture starts on the next edge.
    @(negedge clk);
    rst = 1'b1;
    drive(1, 1, 0, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("reledge_valid_q", 32'(valid_q), 32'd0);
    @(posedge clk); #1;
    chk("relnext_valid_q", 32'(valid_q), 32'd1);
    chk("relnext_c_out_q", 32'(c_out_q), 32'd1);

    // Randomized traffic scored by the monitor.
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0);
    #2;
    rst = 1'b0;
    m_cnt  = 0;
    m_cnt2 = 0;
    mon_en = 1'b1;
    for (int n = 0; n < 300; n++) begin
      exp_t e;
      logic x, y, z, v;
      @(negedge clk);
      x = 1'($urandom); y = 1'($urandom); z = 1'($urandom);
      v = ($urandom_range(0, 3) != 0);
      drive(x, y, z, v);
      r = add3(x, y, z);
      if (v) begin
        if (r >= 2) begin
          m_cnt  = sat(m_cnt + 1, 255);
          m_cnt2 = sat(m_cnt2 + 1, 3);
        end
        e.s = 1'(r % 2); e.co = 1'(r / 2); e.cnt = m_cnt; e.cnt2 = m_cnt2;
        sb.push_back(e);
      end
      #1;
      chk("rnd_sum",   32'(sum),   r % 2);
      chk("rnd_c_out", 32'(c_out), r / 2);
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
